// File: rtl/dsa_step_host_sequencer.sv
// -----------------------------------------------------------------------------
// dsa_step_host_sequencer
//
// Host-side sequencer for single-stepping a DSA core. It takes commands from a
// host/JTAG register, puts the step controller into step mode, issues step
// triggers with a req/ack/ready handshake, and reports how an operation ended.
// Operations can end on step-count exhaustion, a breakpoint match, a handshake
// timeout or an ABORT.
//
// Ports
//   clk, rst            clock; asynchronous active-high reset
//   cmd_valid/cmd_ready command handshake
//   cmd_op              0 NOP, 1 ENTER_STEP, 2 STEP_N, 3 RUN_TO_BP,
//                       4 EXIT_STEP, 5 ABORT, 6-7 NOP
//   cmd_count           step count for STEP_N
//   cmd_gran            step granularity, latched on ENTER_STEP
//   bp_enable, bp_state breakpoint enable and the FSM state code to stop on
//   fsm_state           currently selected DSA FSM state
//   step_ack            step controller accepted the trigger
//   step_ready          step controller finished a step / entered step mode
//   step_enable, step_trigger, step_granularity   to the step controller
//   busy                operation in progress
//   done                one-cycle pulse when an operation ends
//   status              0 OK, 1 BP_HIT, 2 TIMEOUT, 3 ABORTED
//   steps_done          completed steps of the last operation (saturating)
//   snap_state          fsm_state captured at the last completed step
// -----------------------------------------------------------------------------
module dsa_step_host_sequencer #(
    parameter int unsigned CNT_W = 16,
    parameter int unsigned TMO_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    input  logic [2:0]       cmd_op,
    input  logic [CNT_W-1:0] cmd_count,
    input  logic [1:0]       cmd_gran,
    input  logic             bp_enable,
    input  logic [3:0]       bp_state,
    input  logic [3:0]       fsm_state,
    input  logic             step_ack,
    input  logic             step_ready,
    output logic             step_enable,
    output logic             step_trigger,
    output logic [1:0]       step_granularity,
    output logic             cmd_ready,
    output logic             busy,
    output logic             done,
    output logic [1:0]       status,
    output logic [CNT_W-1:0] steps_done,
    output logic [3:0]       snap_state
);

    localparam logic [2:0] OP_ENTER = 3'd1;
    localparam logic [2:0] OP_STEPN = 3'd2;
    localparam logic [2:0] OP_RUNBP = 3'd3;
    localparam logic [2:0] OP_EXIT  = 3'd4;
    localparam logic [2:0] OP_ABORT = 3'd5;

    localparam logic [1:0] ST_OK      = 2'd0;
    localparam logic [1:0] ST_BP_HIT  = 2'd1;
    localparam logic [1:0] ST_TIMEOUT = 2'd2;
    localparam logic [1:0] ST_ABORTED = 2'd3;

    typedef enum logic [2:0] {
        S_FREE,
        S_ENTER,
        S_HALTED,
        S_TRIG,
        S_WAIT_READY,
        S_DONE
    } state_t;

    state_t           state, state_n;
    logic             enable_n;
    logic [1:0]       gran_n;
    logic [1:0]       status_n;
    logic [CNT_W-1:0] steps_n;
    logic [3:0]       snap_n;
    logic [CNT_W-1:0] remaining, remaining_n;
    logic             run_bp, run_bp_n;
    logic [TMO_W-1:0] tmo, tmo_n;

    logic abort_cmd;
    logic accept;
    logic tmo_expired;
    logic bp_match;

    // Decoded outputs come straight from the state register.
    assign cmd_ready    = (state == S_FREE) || (state == S_HALTED);
    assign busy         = (state == S_ENTER) || (state == S_TRIG) || (state == S_WAIT_READY);
    assign done         = (state == S_DONE);
    assign step_trigger = (state == S_TRIG);

    assign abort_cmd   = cmd_valid && (cmd_op == OP_ABORT);
    assign accept      = cmd_valid && cmd_ready;
    assign tmo_expired = (tmo == '1);
    assign bp_match    = bp_enable && (fsm_state == bp_state);

    always_comb begin
        state_n     = state;
        enable_n    = step_enable;
        gran_n      = step_granularity;
        status_n    = status;
        steps_n     = steps_done;
        snap_n      = snap_state;
        remaining_n = remaining;
        run_bp_n    = run_bp;
        tmo_n       = busy ? tmo + TMO_W'(1) : tmo;

        if (abort_cmd) begin
            state_n  = S_DONE;
            status_n = ST_ABORTED;
        end else begin
            case (state)
                S_FREE: begin
                    if (accept && (cmd_op == OP_ENTER)) begin
                        enable_n = 1'b1;
                        gran_n   = cmd_gran;
                        status_n = ST_OK;
                        tmo_n    = '0;
                        state_n  = S_ENTER;
                    end
                end
                S_ENTER: begin
                    if (step_ready) begin
                        status_n = ST_OK;
                        state_n  = S_DONE;
                    end else if (tmo_expired) begin
                        status_n = ST_TIMEOUT;
                        state_n  = S_DONE;
                    end
                end
                S_HALTED: begin
                    if (accept) begin
                        case (cmd_op)
                            OP_STEPN, OP_RUNBP: begin
                                steps_n     = '0;
                                status_n    = ST_OK;
                                remaining_n = cmd_count;
                                run_bp_n    = (cmd_op == OP_RUNBP);
                                tmo_n       = '0;
                                // A zero-length STEP_N completes without triggering.
                                if ((cmd_op == OP_STEPN) && (cmd_count == '0)) begin
                                    state_n = S_DONE;
                                end else begin
                                    state_n = S_TRIG;
                                end
                            end
                            OP_EXIT: begin
                                enable_n = 1'b0;
                                status_n = ST_OK;
                                state_n  = S_DONE;
                            end
                            default: ;
                        endcase
                    end
                end
                S_TRIG: begin
                    if (step_ack) begin
                        state_n = S_WAIT_READY;
                    end else if (tmo_expired) begin
                        status_n = ST_TIMEOUT;
                        state_n  = S_DONE;
                    end
                end
                S_WAIT_READY: begin
                    if (step_ready) begin
                        snap_n      = fsm_state;
                        steps_n     = (steps_done == '1) ? steps_done : steps_done + CNT_W'(1);
                        remaining_n = remaining - CNT_W'(1);
                        tmo_n       = '0;
                        // Breakpoint outranks count exhaustion on the same step.
                        if (bp_match) begin
                            status_n = ST_BP_HIT;
                            state_n  = S_DONE;
                        end else if (!run_bp && (remaining == CNT_W'(1))) begin
                            status_n = ST_OK;
                            state_n  = S_DONE;
                        end else begin
                            state_n = S_TRIG;
                        end
                    end else if (tmo_expired) begin
                        status_n = ST_TIMEOUT;
                        state_n  = S_DONE;
                    end
                end
                S_DONE: begin
                    state_n = step_enable ? S_HALTED : S_FREE;
                end
                default: begin
                    state_n = S_FREE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state            <= S_FREE;
            step_enable      <= 1'b0;
            step_granularity <= '0;
            status           <= ST_OK;
            steps_done       <= '0;
            snap_state       <= '0;
            remaining        <= '0;
            run_bp           <= 1'b0;
            tmo              <= '0;
        end else begin
            state            <= state_n;
            step_enable      <= enable_n;
            step_granularity <= gran_n;
            status           <= status_n;
            steps_done       <= steps_n;
            snap_state       <= snap_n;
            remaining        <= remaining_n;
            run_bp           <= run_bp_n;
            tmo              <= tmo_n;
        end
    end

endmodule
